// File: rtl/vga_pkg.sv
// Shared VGA definitions: active-area geometry, the 12-bit colour type, debounce states and
// small arithmetic helpers used by the renderer and the timing stage.
package vga_pkg;

    localparam int H_ACTIVE = 1440;
    localparam int V_ACTIVE = 900;
    localparam int X_W      = 11;
    localparam int Y_W      = 10;

    typedef struct packed {
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] r;
    } rgb12_t;

    // Bit 1 of the encoding is the accepted button level.
    typedef enum logic [1:0] {
        DEB_IDLE0 = 2'b00,
        DEB_WAIT1 = 2'b01,
        DEB_IDLE1 = 2'b10,
        DEB_WAIT0 = 2'b11
    } deb_state_e;

    function automatic logic signed [12:0] clamp(input logic signed [12:0] v,
                                                 input logic signed [12:0] lo,
                                                 input logic signed [12:0] hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end else begin
            return v;
        end
    endfunction

    // Signed step for one axis; opposite buttons held together cancel.
    function automatic logic signed [12:0] axis_step(input logic neg,
                                                     input logic pos,
                                                     input logic signed [12:0] step);
        if (pos && !neg) begin
            return step;
        end else if (neg && !pos) begin
            return -step;
        end else begin
            return 13'sd0;
        end
    endfunction

endpackage

// File: rtl/rect_renderer_if.sv
// Pixel bus between the VGA timing stage (master) and the rectangle renderer (slave).
interface rect_renderer_if;
    import vga_pkg::*;

    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic           pix_valid;
    logic           frame_tick;
    rgb12_t         fg_colour;
    rgb12_t         rgb;
    logic           rgb_valid;

    modport master (
        output pix_x, pix_y, pix_valid, frame_tick, fg_colour,
        input  rgb, rgb_valid
    );

    modport slave (
        input  pix_x, pix_y, pix_valid, frame_tick, fg_colour,
        output rgb, rgb_valid
    );

endinterface

// File: rtl/rect_renderer_btn_debounce.sv
// btn_debounce: 2-flop synchroniser followed by a four-state debounce FSM; the accepted level
// changes only after the synchronised input has been stable for DEB_CYCLES clocks.
module btn_debounce
    import vga_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    deb_state_e       state_q;
    deb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Synchroniser, state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            state_q <= DEB_IDLE0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Debounce next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            DEB_IDLE0: begin
                if (sync_q[1]) begin
                    state_d = DEB_WAIT1;
                end else begin
                    state_d = DEB_IDLE0;
                end
            end
            DEB_WAIT1: begin
                if (!sync_q[1]) begin
                    state_d = DEB_IDLE0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DEB_IDLE1;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DEB_IDLE1: begin
                if (!sync_q[1]) begin
                    state_d = DEB_WAIT0;
                end else begin
                    state_d = DEB_IDLE1;
                end
            end
            DEB_WAIT0: begin
                if (sync_q[1]) begin
                    state_d = DEB_IDLE1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DEB_IDLE0;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = DEB_IDLE0;
            end
        endcase
    end

    assign level_o = state_q[1];

endmodule

// File: rtl/rect_renderer.sv
// rect_renderer: movable rectangle over a fixed background, 1-clk colour pipeline, position
// updated once per frame. Define RECT_AUTO_BOUNCE_EN to add the auto_en bouncing mode.
module rect_renderer
    import vga_pkg::*;
#(
    parameter int     RECT_W     = 64,
    parameter int     RECT_H     = 48,
    parameter int     STEP       = 4,
    parameter rgb12_t BG_COLOUR  = 12'h000,
    parameter int     DEB_CYCLES = 1_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    rect_renderer_if.slave bus,
    input  logic           btn_up,
    input  logic           btn_down,
    input  logic           btn_left,
    input  logic           btn_right
`ifdef RECT_AUTO_BOUNCE_EN
    ,
    input  logic           auto_en
`endif
);

    localparam logic signed [12:0] STEP_S  = 13'(STEP);
    localparam logic signed [12:0] X_MAX_S = 13'(H_ACTIVE - RECT_W);
    localparam logic signed [12:0] Y_MAX_S = 13'(V_ACTIVE - RECT_H);
    localparam logic [11:0]        X_RST   = 12'((H_ACTIVE - RECT_W) / 2);
    localparam logic [10:0]        Y_RST   = 11'((V_ACTIVE - RECT_H) / 2);

    logic up_s;
    logic down_s;
    logic left_s;
    logic right_s;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up    (.clk(clk), .rst_n(rst_n), .btn_i(btn_up),    .level_o(up_s));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down  (.clk(clk), .rst_n(rst_n), .btn_i(btn_down),  .level_o(down_s));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left  (.clk(clk), .rst_n(rst_n), .btn_i(btn_left),  .level_o(left_s));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (.clk(clk), .rst_n(rst_n), .btn_i(btn_right), .level_o(right_s));

    logic [11:0]        rect_x_q;
    logic [11:0]        rect_x_d;
    logic [10:0]        rect_y_q;
    logic [10:0]        rect_y_d;
    logic signed [12:0] step_x_s;
    logic signed [12:0] step_y_s;
    logic signed [12:0] cand_x_s;
    logic signed [12:0] cand_y_s;
    rgb12_t             rgb_q;
    rgb12_t             rgb_d;
    logic               rgb_valid_q;
    logic               inside_s;

`ifdef RECT_AUTO_BOUNCE_EN
    logic dir_x_q;   // 1 = moving towards smaller x
    logic dir_x_d;
    logic dir_y_q;
    logic dir_y_d;

    // Bounce direction registers, reset to +1 on both axes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_x_q <= 1'b0;
            dir_y_q <= 1'b0;
        end else begin
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
        end
    end
`endif

    // Per-frame step, candidate position and (in bounce mode) edge-hit direction flips
    always_comb begin
        step_x_s = axis_step(left_s, right_s, STEP_S);
        step_y_s = axis_step(up_s, down_s, STEP_S);
`ifdef RECT_AUTO_BOUNCE_EN
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (auto_en) begin
            step_x_s = dir_x_q ? -STEP_S : STEP_S;
            step_y_s = dir_y_q ? -STEP_S : STEP_S;
        end else begin
            step_x_s = axis_step(left_s, right_s, STEP_S);
            step_y_s = axis_step(up_s, down_s, STEP_S);
        end
`endif
        cand_x_s = $signed({1'b0, rect_x_q}) + step_x_s;
        cand_y_s = $signed({2'b00, rect_y_q}) + step_y_s;
`ifdef RECT_AUTO_BOUNCE_EN
        // Touching an edge counts as a hit, so the rectangle never sits past it.
        if (bus.frame_tick && auto_en) begin
            if (cand_x_s <= 13'sd0) begin
                dir_x_d = 1'b0;
            end else if (cand_x_s >= X_MAX_S) begin
                dir_x_d = 1'b1;
            end else begin
                dir_x_d = dir_x_q;
            end
            if (cand_y_s <= 13'sd0) begin
                dir_y_d = 1'b0;
            end else if (cand_y_s >= Y_MAX_S) begin
                dir_y_d = 1'b1;
            end else begin
                dir_y_d = dir_y_q;
            end
        end else begin
            dir_x_d = dir_x_q;
            dir_y_d = dir_y_q;
        end
`endif
        if (bus.frame_tick) begin
            rect_x_d = 12'(clamp(cand_x_s, 13'sd0, X_MAX_S));
            rect_y_d = 11'(clamp(cand_y_s, 13'sd0, Y_MAX_S));
        end else begin
            rect_x_d = rect_x_q;
            rect_y_d = rect_y_q;
        end
    end

    // Position registers, centred at reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rect_x_q <= X_RST;
            rect_y_q <= Y_RST;
        end else begin
            rect_x_q <= rect_x_d;
            rect_y_q <= rect_y_d;
        end
    end

    // Colour selection for the current pixel
    always_comb begin
        inside_s = ({1'b0, bus.pix_x} >= rect_x_q) &&
                   ({1'b0, bus.pix_x} < (rect_x_q + 12'(RECT_W))) &&
                   ({1'b0, bus.pix_y} >= rect_y_q) &&
                   ({1'b0, bus.pix_y} < (rect_y_q + 11'(RECT_H)));
        if (!bus.pix_valid) begin
            rgb_d = 12'h000;
        end else if (inside_s) begin
            rgb_d = bus.fg_colour;
        end else begin
            rgb_d = BG_COLOUR;
        end
    end

    // One-stage colour pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q       <= 12'h000;
            rgb_valid_q <= 1'b0;
        end else begin
            rgb_q       <= rgb_d;
            rgb_valid_q <= bus.pix_valid;
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_rect_renderer.sv
// Directed scoreboard bench for rect_renderer (default build, DEB_CYCLES=4).
module tb_rect_renderer;
    import vga_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   btn_up = 1'b0;
    logic   btn_down = 1'b0;
    logic   btn_left = 1'b0;
    logic   btn_right = 1'b0;
`ifdef RECT_AUTO_BOUNCE_EN
    logic   auto_en = 1'b0;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [12:0] sb_q[$];
    int          mx = 688;
    int          my = 426;
    logic        m_up = 1'b0;
    logic        m_down = 1'b0;
    logic        m_left = 1'b0;
    logic        m_right = 1'b0;
    logic [11:0] fg = 12'hF00;

    always #5 clk = ~clk;

    rect_renderer_if bus();

    rect_renderer #(.DEB_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right)
`ifdef RECT_AUTO_BOUNCE_EN
        ,
        .auto_en   (auto_en)
`endif
    );

    function automatic logic [12:0] expect_pix(input int x, input int y, input logic v,
                                               input int rx, input int ry, input logic [11:0] c);
        logic in_r;
        in_r = (x >= rx) && (x < rx + 64) && (y >= ry) && (y < ry + 48);
        if (!v) return 13'h0000;
        return {1'b1, (in_r ? c : 12'h000)};
    endfunction

    // Drive one pixel at the falling edge, then check the pixel driven one cycle earlier.
    task automatic step(input int x, input int y, input logic v, input logic tick,
                        input int rx, input int ry);
        logic [12:0] exp_v;
        int d;
        @(negedge clk);
        bus.pix_x      = 11'(x);
        bus.pix_y      = 10'(y);
        bus.pix_valid  = v;
        bus.frame_tick = tick;
        bus.fg_colour  = fg;
        sb_q.push_back(expect_pix(x, y, v, rx, ry, fg));
        #1;
        exp_v = sb_q.pop_front();
        n_cmp++;
        assert ({bus.rgb_valid, bus.rgb} === exp_v) else begin
            n_bad++;
            $error("FAIL pix x=%0d y=%0d observed=%h expected=%h", x, y, {bus.rgb_valid, bus.rgb}, exp_v);
        end
        if (tick) begin
            d  = 4 * (int'(m_right) - int'(m_left));
            mx = mx + d;
            if (mx < 0) mx = 0;
            if (mx > 1376) mx = 1376;
            d  = 4 * (int'(m_down) - int'(m_up));
            my = my + d;
            if (my < 0) my = 0;
            if (my > 852) my = 852;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 1'b0, 1'b0, mx, my);
    endtask

    task automatic ticks(input int n);
        repeat (n) step(0, 0, 1'b0, 1'b1, mx, my);
    endtask

    task automatic scan_row(input int y, input int rx, input int ry);
        for (int x = 0; x < 1440; x++) step(x, y, 1'b1, 1'b0, rx, ry);
    endtask

    // Probe the four edges of a rectangle expected at (x0,y0).
    task automatic probe(input int x0, input int y0);
        if (x0 > 0)      step(x0 - 1, y0, 1'b1, 1'b0, x0, y0);
        step(x0, y0, 1'b1, 1'b0, x0, y0);
        step(x0 + 63, y0 + 47, 1'b1, 1'b0, x0, y0);
        if (x0 + 64 < 1440) step(x0 + 64, y0, 1'b1, 1'b0, x0, y0);
        if (y0 > 0)      step(x0, y0 - 1, 1'b1, 1'b0, x0, y0);
        if (y0 + 48 < 900) step(x0, y0 + 48, 1'b1, 1'b0, x0, y0);
    endtask

    initial begin
        bus.pix_x      = 11'd0;
        bus.pix_y      = 10'd0;
        bus.pix_valid  = 1'b0;
        bus.frame_tick = 1'b0;
        bus.fg_colour  = fg;
        repeat (3) @(negedge clk);
        n_cmp++;
        assert ({bus.rgb_valid, bus.rgb} === 13'h0000) else begin
            n_bad++;
            $error("FAIL reset_out observed=%h expected=%h", {bus.rgb_valid, bus.rgb}, 13'h0000);
        end
        rst_n = 1'b1;
        sb_q.push_back(13'h0000);

        // Centre position, background, invalid pixels
        scan_row(0, 688, 426);
        scan_row(425, 688, 426);
        scan_row(426, 688, 426);
        scan_row(473, 688, 426);
        scan_row(474, 688, 426);
        scan_row(899, 688, 426);
        probe(688, 426);
        step(700, 430, 1'b0, 1'b0, 688, 426);
        step(700, 430, 1'b1, 1'b0, 688, 426);
        step(700, 430, 1'b0, 1'b0, 688, 426);

        // Right for 10 frames, then a left glitch that must not move
        btn_right = 1'b1; m_right = 1'b1;
        idle(20);
        ticks(10);
        btn_right = 1'b0; m_right = 1'b0;
        idle(20);
        probe(728, 426);
        btn_left = 1'b1;
        idle(2);
        btn_left = 1'b0;
        idle(20);
        ticks(1);
        probe(728, 426);

        // Clamp at left and bottom edges
        btn_left = 1'b1; m_left = 1'b1;
        idle(20);
        ticks(200);
        btn_left = 1'b0; m_left = 1'b0;
        idle(20);
        probe(0, 426);
        btn_down = 1'b1; m_down = 1'b1;
        idle(20);
        ticks(200);
        btn_down = 1'b0; m_down = 1'b0;
        idle(20);
        probe(0, 852);

        // Opposite buttons cancel
        btn_up = 1'b1; m_up = 1'b1;
        btn_down = 1'b1; m_down = 1'b1;
        idle(20);
        ticks(5);
        btn_up = 1'b0; m_up = 1'b0;
        btn_down = 1'b0; m_down = 1'b0;
        idle(20);
        probe(0, 852);

        // Foreground colour changes mid-line
        for (int x = 0; x < 80; x++) begin
            if (x == 20) fg = 12'h0F0;
            if (x == 41) fg = 12'h00F;
            if (x == 70) fg = 12'hABC;
            step(x, 860, 1'b1, 1'b0, 0, 852);
        end

        // Reset in the middle of a line
        for (int x = 0; x < 10; x++) step(x, 870, 1'b1, 1'b0, 0, 852);
        #2;
        rst_n = 1'b0;
        bus.pix_valid = 1'b0;
        #1;
        n_cmp++;
        assert ({bus.rgb_valid, bus.rgb} === 13'h0000) else begin
            n_bad++;
            $error("FAIL midline_reset observed=%h expected=%h", {bus.rgb_valid, bus.rgb}, 13'h0000);
        end
        sb_q.delete();
        mx = 688;
        my = 426;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back(13'h0000);
        probe(688, 426);
        scan_row(450, 688, 426);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
